// File: rtl/fifo_pkg.sv
// Shared helpers for the FIFO family: depth derivation, log2 and threshold legality checks.
package fifo_pkg;

  function automatic int fifo_clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  // Almost-full must be reachable and non-trivial: 1..DEPTH.
  function automatic bit afull_level_ok(input int level, input int depth);
    return (level >= 1) && (level <= depth);
  endfunction

  // Almost-empty must leave at least one level where the flag is low: 0..DEPTH-1.
  function automatic bit aempty_level_ok(input int level, input int depth);
    return (level >= 0) && (level <= depth - 1);
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM, single clock, registered read with enable (read-first on address collision).
module sdp_ram #(
  parameter int DAT_WIDTH  = 64,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wa,
  input  logic [DAT_WIDTH-1:0]  wd,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] ra,
  output logic [DAT_WIDTH-1:0]  q
);

  logic [DAT_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wa] <= wd;
    end
    if (re) begin
      q <= mem[ra];
    end
  end

endmodule

// File: rtl/sync_fifo_sa.sv
// Single-clock FIFO with show-ahead or normal read, programmable almost flags,
// synchronous flush and sticky overflow/underflow.
module sync_fifo_sa
  import fifo_pkg::*;
#(
  parameter int DAT_WIDTH    = 64,
  parameter int ADDR_WIDTH   = 7,
  parameter int SHOW_AHEAD   = 1,
  parameter int AFULL_LEVEL  = (1 << ADDR_WIDTH) - 4,
  parameter int AEMPTY_LEVEL = 4
) (
  input  logic                  clk,
  input  logic                  aclr_n,
  input  logic                  sclr,
  input  logic [DAT_WIDTH-1:0]  wr_dat,
  input  logic                  wr_req,
  output logic                  wr_full,
  output logic                  wr_afull,
  input  logic                  rd_req,
  output logic [DAT_WIDTH-1:0]  rd_dat,
  output logic                  rd_empty,
  output logic                  rd_aempty,
  output logic [ADDR_WIDTH:0]   rd_used,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);
  localparam int PW    = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH_C  = PW'(DEPTH);
  localparam logic [PW-1:0] AFULL_C  = PW'(AFULL_LEVEL);
  localparam logic [PW-1:0] AEMPTY_C = PW'(AEMPTY_LEVEL);

  generate
    if (!afull_level_ok(AFULL_LEVEL, DEPTH)) begin : g_bad_afull
      $error("sync_fifo_sa: AFULL_LEVEL must be in 1..DEPTH");
    end
    if (!aempty_level_ok(AEMPTY_LEVEL, DEPTH)) begin : g_bad_aempty
      $error("sync_fifo_sa: AEMPTY_LEVEL must be in 0..DEPTH-1");
    end
  endgenerate

  logic [PW-1:0]         wr_ptr_reg, rd_ptr_reg, used_reg;
  logic [PW-1:0]         wr_ptr_next, rd_ptr_next, used_next;
  logic                  full_reg, afull_reg, empty_reg, aempty_reg;
  logic                  ovf_reg, udf_reg;
  logic [DAT_WIDTH-1:0]  head_reg, byp_dat_reg, ram_q, nxt_word;
  logic                  byp_valid_reg, byp_hit;
  logic                  push_ok, pop_ok;
  logic [ADDR_WIDTH-1:0] ram_ra;

  // The RAM always prefetches the word behind the head; byp_* covers the one
  // cycle where that word is being written on the same edge it is read.
  always_comb begin
    push_ok     = wr_req & ~full_reg;
    pop_ok      = rd_req & ~empty_reg;
    wr_ptr_next = wr_ptr_reg + PW'(push_ok);
    rd_ptr_next = rd_ptr_reg + PW'(pop_ok);
    used_next   = used_reg + PW'(push_ok) - PW'(pop_ok);
    byp_hit     = push_ok & (wr_ptr_reg == rd_ptr_next + PW'(1));
    ram_ra      = rd_ptr_next[ADDR_WIDTH-1:0] + ADDR_WIDTH'(1);
    nxt_word    = byp_valid_reg ? byp_dat_reg : ram_q;
  end

  sdp_ram #(
    .DAT_WIDTH (DAT_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk(clk),
    .we (push_ok & ~sclr),
    .wa (wr_ptr_reg[ADDR_WIDTH-1:0]),
    .wd (wr_dat),
    .re (1'b1),
    .ra (ram_ra),
    .q  (ram_q)
  );

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      used_reg      <= '0;
      full_reg      <= 1'b0;
      afull_reg     <= 1'b0;
      empty_reg     <= 1'b1;
      aempty_reg    <= 1'b1;
      ovf_reg       <= 1'b0;
      udf_reg       <= 1'b0;
      byp_valid_reg <= 1'b0;
      byp_dat_reg   <= '0;
    end else if (sclr) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      used_reg      <= '0;
      full_reg      <= 1'b0;
      afull_reg     <= 1'b0;
      empty_reg     <= 1'b1;
      aempty_reg    <= 1'b1;
      ovf_reg       <= 1'b0;
      udf_reg       <= 1'b0;
      byp_valid_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      used_reg      <= used_next;
      full_reg      <= (used_next == DEPTH_C);
      afull_reg     <= (used_next >= AFULL_C);
      empty_reg     <= (used_next == '0);
      aempty_reg    <= (used_next <= AEMPTY_C);
      if (wr_req && full_reg) ovf_reg <= 1'b1;
      if (rd_req && empty_reg) udf_reg <= 1'b1;
      byp_valid_reg <= byp_hit;
      if (byp_hit) byp_dat_reg <= wr_dat;
    end
  end

  // head_reg always mirrors the oldest stored word; it holds across flush and empty.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      head_reg <= '0;
    end else if (!sclr) begin
      if (pop_ok) begin
        if (used_reg > PW'(1)) begin
          head_reg <= nxt_word;
        end else if (push_ok) begin
          head_reg <= wr_dat;
        end
      end else if (push_ok && empty_reg) begin
        head_reg <= wr_dat;
      end
    end
  end

  generate
    if (SHOW_AHEAD != 0) begin : g_show_ahead
      assign rd_dat = head_reg;
    end else begin : g_normal
      logic [DAT_WIDTH-1:0] out_reg;
      always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
          out_reg <= '0;
        end else if (!sclr && pop_ok) begin
          out_reg <= head_reg;
        end
      end
      assign rd_dat = out_reg;
    end
  endgenerate

  assign wr_full   = full_reg;
  assign wr_afull  = afull_reg;
  assign rd_empty  = empty_reg;
  assign rd_aempty = aempty_reg;
  assign rd_used   = used_reg;
  assign overflow  = ovf_reg;
  assign underflow = udf_reg;

endmodule

// File: tb/tb_sync_fifo_sa.sv
// Scoreboard bench: a queue-based reference model drives expectations for a
// show-ahead and a normal-mode instance fed with the same stimulus.
module tb_sync_fifo_sa;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          aclr_n = 1'b0;
  logic          sclr = 1'b0;
  logic [DW-1:0] wr_dat = '0;
  logic          wr_req = 1'b0;
  logic          rd_req = 1'b0;

  logic          wr_full, wr_afull, rd_empty, rd_aempty, overflow, underflow;
  logic [DW-1:0] rd_dat;
  logic [AW:0]   rd_used;
  logic          wr_full_n, wr_afull_n, rd_empty_n, rd_aempty_n, overflow_n, underflow_n;
  logic [DW-1:0] rd_dat_n;
  logic [AW:0]   rd_used_n;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sync_fifo_sa #(.DAT_WIDTH(DW), .ADDR_WIDTH(AW), .SHOW_AHEAD(1),
                 .AFULL_LEVEL(6), .AEMPTY_LEVEL(2)) dut (
    .clk(clk), .aclr_n(aclr_n), .sclr(sclr), .wr_dat(wr_dat), .wr_req(wr_req),
    .wr_full(wr_full), .wr_afull(wr_afull), .rd_req(rd_req), .rd_dat(rd_dat),
    .rd_empty(rd_empty), .rd_aempty(rd_aempty), .rd_used(rd_used),
    .overflow(overflow), .underflow(underflow)
  );

  sync_fifo_sa #(.DAT_WIDTH(DW), .ADDR_WIDTH(AW), .SHOW_AHEAD(0),
                 .AFULL_LEVEL(6), .AEMPTY_LEVEL(2)) dut_n (
    .clk(clk), .aclr_n(aclr_n), .sclr(sclr), .wr_dat(wr_dat), .wr_req(wr_req),
    .wr_full(wr_full_n), .wr_afull(wr_afull_n), .rd_req(rd_req), .rd_dat(rd_dat_n),
    .rd_empty(rd_empty_n), .rd_aempty(rd_aempty_n), .rd_used(rd_used_n),
    .overflow(overflow_n), .underflow(underflow_n)
  );

  // Reference model state
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_sa   = '0;
  logic [DW-1:0] m_out0 = '0;
  logic [DW-1:0] m_popped;
  bit            m_ovf = 1'b0;
  bit            m_udf = 1'b0;
  int            m_sz;
  bit            m_wok, m_rok;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: updates on every accepted edge, resets asynchronously.
  initial begin
    forever begin
      @(posedge clk or negedge aclr_n);
      if (!aclr_n) begin
        mq.delete();
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
        m_sa   = '0;
        m_out0 = '0;
      end else if (sclr) begin
        mq.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        $display("t=%0t flush", $time);
      end else begin
        m_sz  = mq.size();
        m_wok = wr_req && (m_sz < DEPTH);
        m_rok = rd_req && (m_sz > 0);
        if (wr_req && m_sz == DEPTH) m_ovf = 1'b1;
        if (rd_req && m_sz == 0) m_udf = 1'b1;
        if (m_rok) begin
          m_popped = mq.pop_front();
          m_out0   = m_popped;
        end
        if (m_wok) mq.push_back(wr_dat);
        if (mq.size() > 0) m_sa = mq[0];
        if (m_wok || m_rok)
          $display("t=%0t push=%0d(%04h) pop=%0d(%04h) used=%0d", $time,
                   m_wok, wr_dat, m_rok, m_rok ? m_popped : 16'h0, mq.size());
      end
    end
  end

  // Monitor: compares DUT outputs against the model away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("rd_used",   int'(rd_used),   mq.size());
      chk("rd_empty",  int'(rd_empty),  int'(mq.size() == 0));
      chk("wr_full",   int'(wr_full),   int'(mq.size() == DEPTH));
      chk("wr_afull",  int'(wr_afull),  int'(mq.size() >= 6));
      chk("rd_aempty", int'(rd_aempty), int'(mq.size() <= 2));
      chk("overflow",  int'(overflow),  int'(m_ovf));
      chk("underflow", int'(underflow), int'(m_udf));
      chk("rd_dat_sa", int'(rd_dat),    int'(m_sa));
      chk("rd_dat_nrm", int'(rd_dat_n), int'(m_out0));
      chk("rd_used_nrm", int'(rd_used_n), mq.size());
    end
  end

  task automatic drive(input bit w, input logic [DW-1:0] d, input bit r, input bit s);
    wr_req = w;
    wr_dat = d;
    rd_req = r;
    sclr   = s;
    @(posedge clk);
    #1;
  endtask

  int pw, pr;
  int pw_tab[4] = '{70, 30, 50, 95};
  int pr_tab[4] = '{30, 70, 50, 95};

  initial begin
    repeat (3) @(posedge clk);
    #1 aclr_n = 1'b1;
    drive(0, 0, 0, 0);

    // Fill to full, then one push too many
    for (int i = 1; i <= 9; i++) drive(1, DW'(i), 0, 0);
    drive(0, 0, 0, 1);

    // Single word through show-ahead path
    drive(1, 16'hABCD, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 1, 0);
    drive(0, 0, 0, 0);

    // Fill, then stream push+pop with full blocking pushes
    for (int i = 0; i < 8; i++) drive(1, DW'(16'h0100 + i), 0, 0);
    for (int i = 0; i < 32; i++) drive(1, DW'(16'h0200 + i), 1, 0);
    for (int i = 0; i < 16 && mq.size() > 4; i++) drive(0, 0, 1, 0);
    drive(1, 16'h0301, 1, 0);
    drive(1, 16'h0302, 1, 0);

    // Drain, pop on empty, flush clears sticky flags
    for (int i = 0; i < 16 && mq.size() > 0; i++) drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 1);

    // Normal-mode hold behaviour (checked on dut_n)
    drive(1, 16'h0011, 0, 0);
    drive(1, 16'h0022, 0, 0);
    drive(0, 0, 1, 0);
    repeat (3) drive(0, 0, 0, 0);
    drive(0, 0, 1, 0);

    // Flush with a simultaneous push
    for (int i = 0; i < 5; i++) drive(1, DW'(16'h0400 + i), 0, 0);
    drive(1, 16'h04FF, 0, 1);
    drive(0, 0, 0, 0);

    // Async reset mid-burst, checked without a clock edge
    for (int i = 0; i < 3; i++) drive(1, DW'(16'h0500 + i), 0, 0);
    wr_req = 1'b1;
    wr_dat = 16'h0600;
    #1 aclr_n = 1'b0;
    #1;
    chk("aclr_rd_used", int'(rd_used), 0);
    chk("aclr_rd_empty", int'(rd_empty), 1);
    chk("aclr_rd_aempty", int'(rd_aempty), 1);
    chk("aclr_wr_full", int'(wr_full), 0);
    chk("aclr_rd_dat", int'(rd_dat), 0);
    chk("aclr_rd_dat_nrm", int'(rd_dat_n), 0);
    #1 aclr_n = 1'b1;
    @(posedge clk);
    #1;
    drive(1, 16'h0601, 0, 0);
    drive(0, 0, 1, 0);

    // Randomized phases with occasional flush
    for (int ph = 0; ph < 4; ph++) begin
      pw = pw_tab[ph];
      pr = pr_tab[ph];
      for (int i = 0; i < 200; i++) begin
        drive(($urandom_range(0, 99) < pw), DW'($urandom_range(0, 65535)),
              ($urandom_range(0, 99) < pr), ($urandom_range(0, 63) == 0));
      end
    end
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
